// File: rtl/srl_fifo_flags_if.sv
// Stream handshake bundle for srl_fifo_flags.
// master: producer/consumer side driving requests; slave: the FIFO itself.
interface srl_fifo_flags_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;

  modport master (
    output if_write_ce, if_write, if_din, if_read_ce, if_read,
    input  if_full_n, if_dout, if_empty_n
  );

  modport slave (
    input  if_write_ce, if_write, if_din, if_read_ce, if_read,
    output if_full_n, if_dout, if_empty_n
  );
endinterface

// File: rtl/srl_fifo_flags.sv
// Shift-register stream FIFO with registered full/empty handshake,
// occupancy count and programmable almost-full/almost-empty flags.
// if_dout is first-word-fall-through from the shift array at raddr.
// Optional sticky overflow/underflow error flags: define SRL_FIFO_FLAGS_ERR_EN.
module srl_fifo_flags #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  srl_fifo_flags_if.slave     fifo_if,
  output logic [ADDR_WIDTH:0] count,
  output logic                almost_full,
  output logic                almost_empty,
  input  logic                err_clr,
  output logic                overflow_err,
  output logic                underflow_err
);

  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_AE   = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] raddr_r;
  logic [ADDR_WIDTH-1:0] raddr_nxt_s;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH:0]   count_nxt_s;
  logic                  full_n_r;
  logic                  empty_n_r;
  logic                  af_r;
  logic                  ae_r;
  logic                  push_s;
  logic                  pop_s;

  // Accepted transfers: requests are masked by ce and the registered handshake.
  always_comb begin
    push_s = fifo_if.if_write & fifo_if.if_write_ce & full_n_r;
    pop_s  = fifo_if.if_read  & fifo_if.if_read_ce  & empty_n_r;
  end

  // Shift array: new data enters slot 0, older entries move up; not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem_r[i] <= mem_r[i-1];
      end
      mem_r[0] <= fifo_if.if_din;
    end
  end

  // Next occupancy and read address; raddr pins at 0 across the empty<->1 edge.
  always_comb begin
    count_nxt_s = count_r;
    raddr_nxt_s = raddr_r;
    case ({push_s, pop_s})
      2'b10: begin
        count_nxt_s = count_r + CNT_ONE;
        if (count_r == CNT_ZERO) begin
          raddr_nxt_s = raddr_r;
        end else begin
          raddr_nxt_s = raddr_r + ADDR_ONE;
        end
      end
      2'b01: begin
        count_nxt_s = count_r - CNT_ONE;
        if (count_r == CNT_ONE) begin
          raddr_nxt_s = raddr_r;
        end else begin
          raddr_nxt_s = raddr_r - ADDR_ONE;
        end
      end
      default: begin
        count_nxt_s = count_r;
        raddr_nxt_s = raddr_r;
      end
    endcase
  end

  // Occupancy, read pointer and flags all registered from the next count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_r   <= CNT_ZERO;
      raddr_r   <= '0;
      empty_n_r <= 1'b0;
      full_n_r  <= 1'b1;
      af_r      <= 1'b0;
      ae_r      <= 1'b1;
    end else begin
      count_r   <= count_nxt_s;
      raddr_r   <= raddr_nxt_s;
      empty_n_r <= (count_nxt_s != CNT_ZERO);
      full_n_r  <= (count_nxt_s != CNT_FULL);
      af_r      <= (count_nxt_s >= CNT_AF);
      ae_r      <= (count_nxt_s <= CNT_AE);
    end
  end

  assign fifo_if.if_dout    = mem_r[raddr_r];
  assign fifo_if.if_empty_n = empty_n_r;
  assign fifo_if.if_full_n  = full_n_r;
  assign count              = count_r;
  assign almost_full        = af_r;
  assign almost_empty       = ae_r;

`ifdef SRL_FIFO_FLAGS_ERR_EN
  logic ovf_r;
  logic unf_r;
  logic ovf_set_s;
  logic unf_set_s;

  // Error set conditions: a request that the handshake refused.
  always_comb begin
    ovf_set_s = fifo_if.if_write & fifo_if.if_write_ce & ~full_n_r;
    unf_set_s = fifo_if.if_read  & fifo_if.if_read_ce  & ~empty_n_r;
  end

  // Sticky error flags; a new set outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (err_clr) begin
        ovf_r <= 1'b0;
      end
      if (unf_set_s) begin
        unf_r <= 1'b1;
      end else if (err_clr) begin
        unf_r <= 1'b0;
      end
    end
  end

  assign overflow_err  = ovf_r;
  assign underflow_err = unf_r;
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = err_clr;
  assign overflow_err     = 1'b0;
  assign underflow_err    = 1'b0;
`endif

endmodule

// File: tb/tb_srl_fifo_flags.sv
// Scoreboard bench for srl_fifo_flags (DEPTH=16, AF=14, AE=1).
module tb_srl_fifo_flags;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AF    = 14;
  localparam int AE    = 1;

  logic          clk;
  logic          reset_n;
  logic          err_clr;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow_err;
  logic          underflow_err;

  srl_fifo_flags_if #(.DATA_WIDTH(DW)) bus ();

  srl_fifo_flags #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fifo_if       (bus.slave),
    .count         (count),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .err_clr       (err_clr),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int              checks = 0;
  int              errors = 0;
  logic [DW-1:0]   sb_q[$];
  logic            m_ovf = 1'b0;
  logic            m_unf = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Compare every observable output with the model (called away from the edge).
  task automatic check_state();
    int n;
    n = sb_q.size();
    check("count",         32'(count),             32'(n));
    check("empty_n",       32'(bus.if_empty_n),    32'(n != 0));
    check("full_n",        32'(bus.if_full_n),     32'(n != DEPTH));
    check("almost_full",   32'(almost_full),       32'(n >= AF));
    check("almost_empty",  32'(almost_empty),      32'(n <= AE));
    check("overflow_err",  32'(overflow_err),      32'(m_ovf));
    check("underflow_err", 32'(underflow_err),     32'(m_unf));
    if (n > 0) check("dout", bus.if_dout, sb_q[0]);
  endtask

  task automatic drive_idle();
    bus.if_write    = 1'b0;
    bus.if_write_ce = 1'b0;
    bus.if_din      = 32'h0;
    bus.if_read     = 1'b0;
    bus.if_read_ce  = 1'b0;
    err_clr         = 1'b0;
  endtask

  // One clock: check, drive, update the scoreboard after the edge.
  task automatic step(input logic wr, input logic wce, input logic rd, input logic rce,
                      input logic [DW-1:0] d, input logic clr);
    logic push_ok, pop_ok, ovf_set, unf_set;
    int n;
    check_state();
    n = sb_q.size();
    bus.if_write    = wr;
    bus.if_write_ce = wce;
    bus.if_din      = d;
    bus.if_read     = rd;
    bus.if_read_ce  = rce;
    err_clr         = clr;
    push_ok = wr && wce && (n < DEPTH);
    pop_ok  = rd && rce && (n > 0);
    ovf_set = wr && wce && (n == DEPTH);
    unf_set = rd && rce && (n == 0);
    @(posedge clk);
    if (pop_ok)  void'(sb_q.pop_front());
    if (push_ok) sb_q.push_back(d);
`ifdef SRL_FIFO_FLAGS_ERR_EN
    if (ovf_set) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (unf_set) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
`else
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (ovf_set || unf_set || clr) m_ovf = 1'b0;
`endif
    @(negedge clk);
    drive_idle();
  endtask

  // One reset cycle, optionally with a write that must be discarded.
  task automatic do_reset(input logic with_push);
    reset_n         = 1'b0;
    bus.if_write    = with_push;
    bus.if_write_ce = with_push;
    bus.if_din      = 32'hDEAD_BEEF;
    @(posedge clk);
    sb_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    drive_idle();
  endtask

  task automatic push(input logic [DW-1:0] d);
    step(1'b1, 1'b1, 1'b0, 1'b0, d, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    clk     = 1'b0;
    reset_n = 1'b0;
    drive_idle();
    do_reset(1'b0);

    // 1: reset state, single push falls through.
    check("rst_count", 32'(count), 32'd0);
    check("rst_ae",    32'(almost_empty), 32'd1);
    push(32'hA5);
    check("fwft_dout", bus.if_dout, 32'hA5);
    idle();
    pop();
    idle();

    // ce low means no request.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h77, 1'b0);
    idle();

    // 2: fill to full, dropped extra write, drain in order.
    for (int i = 0; i < DEPTH; i++) push(32'(i));
    check("full_flag", 32'(bus.if_full_n), 32'd0);
    push(32'hFF);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++) pop();
    check("drained", 32'(bus.if_empty_n), 32'd0);
    idle();

    // 3: steady state with simultaneous push and pop at count 8.
    for (int i = 0; i < 8; i++) push(32'(i));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 32'(100 + i), 1'b0);
    check("steady_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) pop();
    idle();

    // 4: simultaneous push/pop when full, then when empty.
    for (int i = 0; i < DEPTH; i++) push(32'(200 + i));
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h55, 1'b0);
    check("full_pp_count", 32'(count), 32'd15);
    for (int i = 0; i < DEPTH - 1; i++) pop();
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h66, 1'b0);
    check("empty_pp_count", 32'(count), 32'd1);
    pop();
    idle();

    // 5: reset mid-operation with a concurrent push.
    for (int i = 0; i < 5; i++) push(32'(300 + i));
    do_reset(1'b1);
    idle();
    push(32'h3C);
    check("post_rst_dout", bus.if_dout, 32'h3C);
    pop();
    idle();

    // 6: error flags (all zero when the feature is not built).
    for (int i = 0; i < DEPTH; i++) push(32'(400 + i));
    push(32'hBAD);
    idle();
    idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle();
    for (int i = 0; i < DEPTH; i++) pop();
    pop();
    idle();
    // set and clear together: set wins
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1);
    idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
